// File: rtl/intm_rs.sv
// rtl/intm_rs.sv - reservation station for the integer multiply/divide pipe
// Holds MD uops, captures CDB results, and issues the oldest ready uop to fu_md.
module intm_rs #(
  parameter int DEPTH     = 4,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int CDB_WIDTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  ds_valid,
  output logic                                  ds_ready,
  input  logic [3:0]                            ds_fu_opcode,
  input  logic [ROB_IDX_W-1:0]                  ds_rob_id,
  input  logic [PRF_IDX_W-1:0]                  ds_rd_phy,
  input  logic [PRF_IDX_W-1:0]                  ds_rs1_phy,
  input  logic [PRF_IDX_W-1:0]                  ds_rs2_phy,
  input  logic                                  ds_rs1_rdy,
  input  logic                                  ds_rs2_rdy,
  input  logic [31:0]                           ds_rs1_value,
  input  logic [31:0]                           ds_rs2_value,
  input  logic [CDB_WIDTH-1:0]                  cdb_valid,
  input  logic [CDB_WIDTH*PRF_IDX_W-1:0]        cdb_rd_phy,
  input  logic [CDB_WIDTH*32-1:0]               cdb_rd_value,
  output logic                                  prv_valid,
  input  logic                                  prv_ready,
  output logic [4+ROB_IDX_W+PRF_IDX_W+63:0]     intm_rs_reg
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_s1_rdy;
  logic [DEPTH-1:0]     r_s2_rdy;
  logic [3:0]           r_op     [DEPTH];
  logic [ROB_IDX_W-1:0] r_rob    [DEPTH];
  logic [PRF_IDX_W-1:0] r_rd     [DEPTH];
  logic [PRF_IDX_W-1:0] r_s1_phy [DEPTH];
  logic [PRF_IDX_W-1:0] r_s2_phy [DEPTH];
  logic [31:0]          r_s1_val [DEPTH];
  logic [31:0]          r_s2_val [DEPTH];
  // r_older[i][j] set means entry j was dispatched before entry i
  logic [DEPTH-1:0]     r_older  [DEPTH];
  logic                 r_lock;
  logic [IDX_W-1:0]     r_lock_idx;

  logic [DEPTH-1:0]     w_elig;
  logic [IDX_W-1:0]     w_oldest_idx;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_has_free;
  logic [32:0]          w_wk1 [DEPTH];
  logic [32:0]          w_wk2 [DEPTH];
  logic [32:0]          w_bp1;
  logic [32:0]          w_bp2;
  logic                 w_issue;
  logic                 w_disp;

  // {hit, value}; ports scanned high to low so the lowest matching port wins
  function automatic logic [32:0] cdb_lookup(input logic [PRF_IDX_W-1:0] tag);
    logic [32:0] res;
    res = '0;
    for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_rd_phy[p*PRF_IDX_W +: PRF_IDX_W] == tag)) begin
        res = {1'b1, cdb_rd_value[p*32 +: 32]};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_elig       = r_valid & r_s1_rdy & r_s2_rdy;
    w_oldest_idx = '0;
    w_free_idx   = '0;
    w_has_free   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_elig[i] && ((r_older[i] & w_elig) == '0)) begin
        w_oldest_idx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
        w_has_free = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = cdb_lookup(r_s1_phy[i]);
      w_wk2[i] = cdb_lookup(r_s2_phy[i]);
    end
    w_bp1 = cdb_lookup(ds_rs1_phy);
    w_bp2 = cdb_lookup(ds_rs2_phy);
  end

  assign w_sel_idx   = r_lock ? r_lock_idx : w_oldest_idx;
  assign ds_ready    = w_has_free && !flush && !rst;
  assign prv_valid   = (|w_elig) && !flush && !rst;
  assign w_issue     = prv_valid && prv_ready;
  assign w_disp      = ds_valid && ds_ready;
  assign intm_rs_reg = prv_valid ? {r_op[w_sel_idx], r_rob[w_sel_idx], r_rd[w_sel_idx],
                                    r_s1_val[w_sel_idx], r_s2_val[w_sel_idx]} : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
      r_lock  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && !r_s1_rdy[i] && w_wk1[i][32]) begin
          r_s1_rdy[i] <= 1'b1;
          r_s1_val[i] <= w_wk1[i][31:0];
        end
        if (r_valid[i] && !r_s2_rdy[i] && w_wk2[i][32]) begin
          r_s2_rdy[i] <= 1'b1;
          r_s2_val[i] <= w_wk2[i][31:0];
        end
      end
      if (w_issue) begin
        r_valid[w_sel_idx] <= 1'b0;
        r_lock             <= 1'b0;
      end else if (prv_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_sel_idx;
      end
      if (w_disp) begin
        r_valid[w_free_idx]  <= 1'b1;
        r_op[w_free_idx]     <= ds_fu_opcode;
        r_rob[w_free_idx]    <= ds_rob_id;
        r_rd[w_free_idx]     <= ds_rd_phy;
        r_s1_phy[w_free_idx] <= ds_rs1_phy;
        r_s2_phy[w_free_idx] <= ds_rs2_phy;
        r_s1_rdy[w_free_idx] <= ds_rs1_rdy || w_bp1[32];
        r_s2_rdy[w_free_idx] <= ds_rs2_rdy || w_bp2[32];
        r_s1_val[w_free_idx] <= ds_rs1_rdy ? ds_rs1_value : w_bp1[31:0];
        r_s2_val[w_free_idx] <= ds_rs2_rdy ? ds_rs2_value : w_bp2[31:0];
        r_older[w_free_idx]  <= r_valid;
        // a reused slot is younger than everything, so clear its stale column
        for (int j = 0; j < DEPTH; j++) begin
          r_older[j][w_free_idx] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/intm_rs.md
# intm_rs

Reservation station for the integer multiply/divide pipe. It sits between dispatch/rename and `fu_md`. It holds up to DEPTH MD uops and captures source operand values from the CDB as they are broadcast. Each cycle it issues the oldest fully-ready uop to `fu_md` over a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4, number of entries (power of 2, ≥2)
- PRF_IDX_W, 6, physical register tag width
- ROB_IDX_W, 5, ROB index width
- CDB_WIDTH, 2, number of CDB broadcast ports

Ports:
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  squash all entries
- ds_valid  in  1  dispatch uop valid
- ds_ready  out  1  at least one free entry
- ds_fu_opcode  in  4  MD opcode (MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU)
- ds_rob_id  in  ROB_IDX_W  ROB index
- ds_rd_phy  in  PRF_IDX_W  destination tag
- ds_rs1_phy, ds_rs2_phy  in  PRF_IDX_W  source tags
- ds_rs1_rdy, ds_rs2_rdy  in  1  source value already available
- ds_rs1_value, ds_rs2_value  in  32  source value (meaningful only when the matching rdy bit is 1)
- cdb_valid  in  CDB_WIDTH  broadcast valid per port
- cdb_rd_phy  in  CDB_WIDTH×PRF_IDX_W  broadcast tags
- cdb_rd_value  in  CDB_WIDTH×32  broadcast values
- prv_valid  out  1  issue valid to fu_md
- prv_ready  in  1  fu_md accepts
- intm_rs_reg  out  intm_rs_reg_t  payload {fu_opcode, rob_id, rd_phy, rs1_value, rs2_value}

## Operation
Entry state:
- Each entry holds valid, opcode, rob_id, rd_phy, and per source {phy, rdy, value}.
- Each entry also records its dispatch order (oldest = earliest accepted).

Dispatch:
- A uop is accepted when ds_valid && ds_ready. It is written into the lowest-index free entry.
- ds_ready = (any entry invalid) && !flush && !rst. It is computed from current state only; an issue in the same cycle does not free an entry for that cycle's dispatch.

Same-cycle bypass at dispatch:
- If a source has rdy=0 and a cdb_valid port's tag matches it in the acceptance cycle, the entry is written with rdy=1 and that port's value.

Wakeup:
- Every cycle, every valid entry with a non-ready source compares that source's tag against all valid CDB ports.
- On a match, the entry sets rdy and captures the value. If multiple ports match, the lowest port index wins.

Select:
- Eligible entries are valid entries with both rdy bits set, using registered state only.
- prv_valid = any eligible entry. The payload is driven from the selected entry's registers.

Stall lock:
- If prv_valid && !prv_ready, the presented entry is locked. The same entry and an unchanged payload are presented until accepted, even if an older entry becomes eligible.
- The lock releases on acceptance or flush.

Issue:
- On prv_valid && prv_ready, the presented entry is invalidated at the edge.

Flush:
- All entries and the lock are cleared at the edge.
- In the flush cycle, prv_valid=0 and ds_ready=0. Any dispatch or issue in that cycle is dropped.

Reset:
- All entries are invalid and the lock is clear.
- While rst=1: prv_valid=0, ds_ready=0, intm_rs_reg=0.

## Timing
- Dispatch with both sources ready, accepted at edge N: prv_valid is high in cycle N+1 at the earliest.
- CDB broadcast in cycle N that completes an entry's operands: that entry is eligible in cycle N+1. There is no same-cycle wakeup-to-issue.
- Throughput is one issue per cycle and one dispatch per cycle; dispatch and issue can occur in the same cycle.
- Full: when DEPTH entries are valid, ds_ready=0. It returns to 1 the cycle after an issue.
- Empty: prv_valid=0.
- An entry can never be both woken up and issued in the same cycle, because eligibility uses registered rdy.

## Test plan
- Single issue: after reset, dispatch MD_MUL with rob_id 3, rs1=0x5 and rs2=0x3 both ready, prv_ready=1 -> next cycle prv_valid=1 with fu_opcode MD_MUL, rs1_value 0x5, rs2_value 0x3, rob_id 3; the cycle after, prv_valid=0.
- Wakeup: dispatch MD_MULH with rs1_phy=12 not ready and rs2=0x39 ready -> prv_valid stays 0. Then CDB port 1 broadcasts tag 12 with value 0xFFFFFFFF -> next cycle prv_valid=1, rs1_value=0xFFFFFFFF.
- Fill/order: with prv_ready=0, dispatch 4 ready uops with rob_id 0..3 -> ds_ready=0 after the 4th, and a 5th ds_valid is not accepted. Then raise prv_ready -> issues occur in rob_id order 0,1,2,3 on consecutive cycles, and ds_ready=1 one cycle after the first issue.
- Stall lock: entry rob 1 is ready and presented with prv_ready=0; the older rob 0 then wakes via CDB -> rob 1 stays presented with a stable payload. Raise prv_ready -> rob 1 issues, then rob 0.
- Dispatch bypass: dispatch with rs2_phy=7 not ready while CDB port 0 broadcasts tag 7 with value 0x39 in the same cycle -> issues next cycle with rs2_value=0x39.
- Flush: 3 entries valid and a stalled presented entry; assert flush for one cycle -> prv_valid=0 in the flush cycle and afterwards, ds_ready=1 the following cycle, and no uop issues.
